// File: rtl/os_loader_if.sv
// ROM read port and instruction-memory write port used by the boot-image copy engine.
// The loader drives the master side; the memory models or wrappers sit on the slave side.
interface os_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              imem_ready;

  modport master (
    output rom_en, rom_addr, imem_we, imem_addr, imem_wdata,
    input  rom_data, imem_ready
  );

  modport slave (
    input  rom_en, rom_addr, imem_we, imem_addr, imem_wdata,
    output rom_data, imem_ready
  );
endinterface

// File: rtl/os_loader.sv
// Boot-image copy engine for the LOAD_OS phase: ROM -> instruction memory, one word per
// READ/CAPTURE/WRITE pass, with a running checksum and a one-cycle done pulse.
module os_loader #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int IMAGE_WORDS = 256,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              abort,
  os_loader_if.master       mem,
  output logic              busy,
  output logic              load_os_done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMAGE_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              rom_en_q, rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    checksum_d   = checksum_q;
    imem_wdata_d = imem_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          idx_d      = '0;
          checksum_d = '0;
          state_d    = S_READ;
        end
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        imem_wdata_d = mem.rom_data;
        state_d      = S_WRITE;
      end
      S_WRITE: begin
        if (mem.imem_ready) begin
          checksum_d = checksum_q + imem_wdata_q;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Abort overrides any same-cycle accept: the checksum keeps its partial value.
    if (abort && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      idx_d      = idx_q;
      checksum_d = checksum_q;
    end

    // Outputs are registered from the next state so nothing combinational reaches a port.
    rom_en_d     = (state_d == S_READ);
    rom_addr_d   = (state_d == S_READ) ? idx_d : '0;
    imem_we_d    = (state_d == S_WRITE);
    imem_addr_d  = (state_d == S_WRITE) ? BASE + idx_d : '0;
    imem_wdata_d = (state_d == S_WRITE) ? imem_wdata_d : '0;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the pre-edge values;
    // the reset is synchronous, so it lives inside the clocked branch.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      checksum_q   <= '0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      checksum_q   <= checksum_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign mem.rom_en     = rom_en_q;
  assign mem.rom_addr   = rom_addr_q;
  assign mem.imem_we    = imem_we_q;
  assign mem.imem_addr  = imem_addr_q;
  assign mem.imem_wdata = imem_wdata_q;
  assign busy           = busy_q;
  assign load_os_done   = done_q;
  assign checksum       = checksum_q;

endmodule

// File: tb/tb_os_loader.sv
// Self-checking bench for os_loader with a 4-word image: a scoreboard of expected
// (address, data, cycle) writes plus per-scenario timing and checksum checks.
module tb_os_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int WORDS  = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_start;
  logic              abort;
  logic              busy;
  logic              load_os_done;
  logic [DATA_W-1:0] checksum;
  logic [DATA_W-1:0] rom_mem [WORDS];

  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;
  int  t0          = 0;
  wr_t exp_q [$];

  os_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  os_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMAGE_WORDS(WORDS), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .abort(abort),
    .mem(bus.master), .busy(busy), .load_os_done(load_os_done), .checksum(checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: one-cycle read latency, garbage when not enabled.
  always @(posedge clk)
    bus.rom_data <= bus.rom_en ? rom_mem[bus.rom_addr[1:0]] : 32'hDEAD_BEEF;

  // Scoreboard: every accepted write must match the oldest expected write, including its cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.imem_we === 1'b1 && bus.imem_ready === 1'b1) begin
      wr_t e;
      int  rel;
      rel = cyc - t0 + 1;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%0h data=%h cycle=%0d, required none",
                 bus.imem_addr, bus.imem_wdata, rel);
      end else begin
        e = exp_q.pop_front();
        if (bus.imem_addr !== e.addr || bus.imem_wdata !== e.data || rel != e.cyc) begin
          miscompares++;
          $display("FAIL write: got addr=%0h data=%h cycle=%0d, required addr=%0h data=%h cycle=%0d",
                   bus.imem_addr, bus.imem_wdata, rel, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic load_rom(input logic [DATA_W-1:0] w0, w1, w2, w3);
    rom_mem[0] = w0; rom_mem[1] = w1; rom_mem[2] = w2; rom_mem[3] = w3;
  endtask

  task automatic push_wr(input int addr, input logic [DATA_W-1:0] data, input int c);
    wr_t e;
    e.addr = ADDR_W'(addr);
    e.data = data;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Unstalled load starting after cycle `off`: word i written in cycle off+3*(i+1).
  task automatic push_image(input int off);
    for (int i = 0; i < WORDS; i++) push_wr(i, rom_mem[i], off + 3 * (i + 1));
  endtask

  // Pulse load_start so it is sampled at edge E0; returns at the start of cycle 1.
  task automatic start_pulse();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic check_queue_empty(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_pending_writes: got %0d left, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_start = 1'b0; abort = 1'b0; bus.imem_ready = 1'b1;
    load_rom(32'h11, 32'h22, 32'h33, 32'h44);
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.rom_en, bus.rom_addr, bus.imem_we, bus.imem_addr, bus.imem_wdata,
         busy, load_os_done, checksum} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rom_en=%b rom_addr=%0h we=%b addr=%0h wdata=%h busy=%b done=%b sum=%h, required all 0",
               bus.rom_en, bus.rom_addr, bus.imem_we, bus.imem_addr, bus.imem_wdata,
               busy, load_os_done, checksum);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    int done_cnt = 0, done_cyc = -1;
    load_rom(32'h11, 32'h22, 32'h33, 32'h44);
    push_image(0);
    bus.imem_ready = 1'b1;
    start_pulse();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        vectors++;
        if (busy !== 1'b1 || bus.rom_en !== 1'b1 || bus.rom_addr !== 10'd0) begin
          miscompares++;
          $display("FAIL basic_cycle1: got busy=%b rom_en=%b rom_addr=%0h, required 1 1 0",
                   busy, bus.rom_en, bus.rom_addr);
        end
      end
      if (load_os_done === 1'b1) begin done_cnt++; done_cyc = k; end
      if (k == 14) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_busy_fall: got busy=%b in cycle 14, required 0", busy);
        end
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (done_cnt != 1 || done_cyc != 13) begin
      miscompares++;
      $display("FAIL basic_done: got %0d pulses last at cycle %0d, required 1 at cycle 13", done_cnt, done_cyc);
    end
    vectors++;
    if (checksum !== 32'hAA) begin
      miscompares++;
      $display("FAIL basic_checksum: got %h, required 000000aa", checksum);
    end
    check_queue_empty("basic");
  endtask

  task automatic test_stall();
    int done_cnt = 0, done_cyc = -1;
    load_rom(32'h11, 32'h22, 32'h33, 32'h44);
    push_wr(0, 32'h11, 3); push_wr(1, 32'h22, 8); push_wr(2, 32'h33, 11); push_wr(3, 32'h44, 14);
    bus.imem_ready = 1'b1;
    start_pulse();
    for (int k = 1; k <= 20; k++) begin
      bus.imem_ready = !(k == 6 || k == 7);
      @(negedge clk);
      if (k >= 6 && k <= 8) begin
        vectors++;
        if (bus.imem_we !== 1'b1 || bus.imem_addr !== 10'd1 || bus.imem_wdata !== 32'h22) begin
          miscompares++;
          $display("FAIL stall_hold c%0d: got we=%b addr=%0h data=%h, required 1 1 00000022",
                   k, bus.imem_we, bus.imem_addr, bus.imem_wdata);
        end
      end
      if (load_os_done === 1'b1) begin done_cnt++; done_cyc = k; end
      @(posedge clk); #1;
    end
    bus.imem_ready = 1'b1;
    vectors++;
    if (done_cnt != 1 || done_cyc != 15) begin
      miscompares++;
      $display("FAIL stall_done: got %0d pulses last at cycle %0d, required 1 at cycle 15", done_cnt, done_cyc);
    end
    vectors++;
    if (checksum !== 32'hAA) begin
      miscompares++;
      $display("FAIL stall_checksum: got %h, required 000000aa", checksum);
    end
    check_queue_empty("stall");
  endtask

  task automatic test_wrap();
    load_rom(32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0);
    push_image(0);
    start_pulse();
    repeat (16) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (checksum !== 32'h1) begin
      miscompares++;
      $display("FAIL wrap_checksum: got %h, required 00000001", checksum);
    end
    check_queue_empty("wrap");
  endtask

  task automatic test_abort();
    int done_cnt = 0;
    load_rom(32'h11, 32'h22, 32'h33, 32'h44);
    // The word-2 write is still accepted by memory in the abort cycle.
    push_wr(0, 32'h11, 3); push_wr(1, 32'h22, 6); push_wr(2, 32'h33, 9);
    start_pulse();
    for (int k = 1; k <= 20; k++) begin
      abort = (k == 9);
      @(negedge clk);
      if (load_os_done === 1'b1) done_cnt++;
      if (k == 10) begin
        vectors++;
        if (busy !== 1'b0 || bus.rom_en !== 1'b0 || bus.imem_we !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_idle: got busy=%b rom_en=%b we=%b, required 0 0 0",
                   busy, bus.rom_en, bus.imem_we);
        end
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    vectors++;
    if (done_cnt != 0) begin
      miscompares++;
      $display("FAIL abort_done: got %0d pulses, required 0", done_cnt);
    end
    vectors++;
    if (checksum !== 32'h33) begin
      miscompares++;
      $display("FAIL abort_checksum: got %h, required 00000033", checksum);
    end
    check_queue_empty("abort");
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0, done_cyc = -1;
    load_rom(32'h11, 32'h22, 32'h33, 32'h44);
    push_wr(0, 32'h11, 3);
    start_pulse();
    for (int k = 1; k <= 8; k++) begin
      rst_n = !(k == 5);
      @(negedge clk);
      if (k == 6) begin
        vectors++;
        if ({bus.rom_en, bus.rom_addr, bus.imem_we, bus.imem_addr, bus.imem_wdata,
             busy, load_os_done, checksum} !== '0) begin
          miscompares++;
          $display("FAIL midreset_outputs: got rom_en=%b we=%b addr=%0h wdata=%h busy=%b sum=%h, required all 0",
                   bus.rom_en, bus.imem_we, bus.imem_addr, bus.imem_wdata, busy, checksum);
        end
      end
      if (k == 8) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL midreset_stays_idle: got busy=%b, required 0", busy);
        end
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    check_queue_empty("midreset_partial");
    push_image(0);
    start_pulse();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (load_os_done === 1'b1) begin done_cnt++; done_cyc = k; end
      @(posedge clk); #1;
    end
    vectors++;
    if (done_cnt != 1 || done_cyc != 13 || checksum !== 32'hAA) begin
      miscompares++;
      $display("FAIL midreset_reload: got %0d pulses at cycle %0d sum=%h, required 1 at 13 sum=000000aa",
               done_cnt, done_cyc, checksum);
    end
    check_queue_empty("midreset");
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0, done_first = -1, done_last = -1;
    load_rom(32'h11, 32'h22, 32'h33, 32'h44);
    push_image(0);
    push_image(14);
    start_pulse();
    for (int k = 1; k <= 32; k++) begin
      load_start = (k == 4) || (k == 14);
      @(negedge clk);
      if (load_os_done === 1'b1) begin
        done_cnt++;
        if (done_first < 0) done_first = k;
        done_last = k;
      end
      if (k == 14) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_idle_gap: got busy=%b in cycle 14, required 0", busy);
        end
      end
      if (k == 15) begin
        vectors++;
        if (busy !== 1'b1 || bus.rom_en !== 1'b1 || bus.rom_addr !== 10'd0) begin
          miscompares++;
          $display("FAIL b2b_restart: got busy=%b rom_en=%b rom_addr=%0h, required 1 1 0",
                   busy, bus.rom_en, bus.rom_addr);
        end
      end
      if (k == 16) begin
        vectors++;
        if (checksum !== 32'h0) begin
          miscompares++;
          $display("FAIL b2b_checksum_clear: got %h, required 00000000", checksum);
        end
      end
      @(posedge clk); #1;
    end
    load_start = 1'b0;
    vectors++;
    if (done_cnt != 2 || done_first != 13 || done_last != 27) begin
      miscompares++;
      $display("FAIL b2b_done: got %0d pulses at %0d and %0d, required 2 at 13 and 27",
               done_cnt, done_first, done_last);
    end
    vectors++;
    if (checksum !== 32'hAA) begin
      miscompares++;
      $display("FAIL b2b_checksum: got %h, required 000000aa", checksum);
    end
    check_queue_empty("b2b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
